// File: rtl/signed_window_acc.sv
// signed_window_acc
// Purpose : sums N signed IW-bit samples per window and emits the sum
//           saturated to OW bits, with a flag when clipping occurred.
// Ports   : clk, rst (async active-high)
//           din/din_valid/din_ready   - upstream sample handshake
//           dout/dout_valid/dout_ready - downstream result handshake
//           sat_flag                   - dout was clipped (qualified by dout_valid)
// Latency : result valid one cycle after the Nth accepted sample; held until drained.
module signed_window_acc #(
  parameter int IW = 4,
  parameter int OW = 6,
  parameter int N  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [IW-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic signed [OW-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 sat_flag
);

  // N >= 2, so the count always needs at least one bit.
  localparam int CW = $clog2(N);
  // Wide enough that N full-scale samples can never overflow.
  localparam int AW = IW + CW;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [OW-1:0] dout_q, dout_d;
  logic                 sat_q, sat_d;

  logic signed [AW-1:0] din_ext;
  logic signed [AW-1:0] sum;
  logic signed [OW-1:0] sat_val;
  logic                 clip;
  logic                 accept;
  logic                 last;

  assign din_ext = {{CW{din[IW-1]}}, din};
  assign sum     = acc_q + din_ext;

  // Saturation of the running sum into the output width. Which branch
  // exists depends only on the parameters; when the output is at least as
  // wide as the accumulator no value can ever clip.
  generate
    if (OW > AW) begin : g_widen
      assign sat_val = {{(OW-AW){sum[AW-1]}}, sum};
      assign clip    = 1'b0;
    end else if (OW == AW) begin : g_same
      assign sat_val = sum;
      assign clip    = 1'b0;
    end else begin : g_clip
      // +2^(OW-1)-1 and -2^(OW-1) expressed at accumulator width.
      localparam logic signed [AW-1:0] MAX_V = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
      localparam logic signed [AW-1:0] MIN_V = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};
      logic hi;
      logic lo;
      assign hi      = (sum > MAX_V);
      assign lo      = (sum < MIN_V);
      assign clip    = hi | lo;
      assign sat_val = hi ? MAX_V[OW-1:0] :
                       lo ? MIN_V[OW-1:0] :
                            sum[OW-1:0];
    end
  endgenerate

  // Ready is a function of state alone so upstream never sees a
  // combinational path back from its own valid.
  assign din_ready  = (state_q == ST_ACC);
  assign dout_valid = (state_q == ST_HOLD);
  assign dout       = dout_q;
  assign sat_flag   = sat_q;

  assign accept = din_valid & din_ready;
  assign last   = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    sat_d   = sat_q;
    case (state_q)
      ST_ACC: begin
        if (accept) begin
          if (last) begin
            // Window complete: capture the saturated total and park.
            state_d = ST_HOLD;
            dout_d  = sat_val;
            sat_d   = clip;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_HOLD: begin
        // Input is refused for the whole hold, including the drain cycle,
        // so the next window starts cleanly the cycle after the transfer.
        if (dout_ready) begin
          state_d = ST_ACC;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_ACC;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: doc/signed_window_acc.md
SIGNED_WINDOW_ACC -- requirements
Module: signed_window_acc

Interface
REQ-001 Parameter IW, default 4, width of the signed input sample (two's complement).
REQ-002 Parameter OW, default 6, width of the signed output sum (two's complement).
REQ-003 Parameter N, default 8, samples per window; legal range 2..256.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; asynchronous assertion, active-high.
REQ-006 din  input  IW  signed sample from the upstream sign-reduction stage.
REQ-007 din_valid  input  1  din carries a sample this cycle.
REQ-008 din_ready  output  1  block accepts a sample this cycle.
REQ-009 dout  output  OW  saturated signed window sum.
REQ-010 dout_valid  output  1  dout holds a completed window result.
REQ-011 dout_ready  input  1  downstream consumes dout this cycle.
REQ-012 sat_flag  output  1  dout was clipped; qualified by dout_valid.

Function
REQ-013 Internal accumulator width AW = IW + clog2(N); each sample is sign-extended to AW before addition, so the accumulator never overflows.
REQ-014 Two states: ACC (collecting) and HOLD (result pending).
REQ-015 din_ready = 1 in ACC and 0 in HOLD; combinational from state only, independent of din_valid.
REQ-016 A sample is accepted when din_valid && din_ready at a rising edge; cycles with din_valid=0 are bubbles and change neither the accumulator nor the sample count.
REQ-017 Each accept adds din to the accumulator and increments the sample count (0..N-1).
REQ-018 On the Nth accept: state -> HOLD; dout <= sat(acc + din); sat_flag <= clip indicator; dout_valid = 1 from the next cycle (latency 1 cycle after the final accept).
REQ-019 sat(x) = x clipped to [-2^(OW-1), 2^(OW-1)-1]; sat_flag = 1 only when clipping occurred; when OW >= AW, no clipping and sat_flag is constant 0.
REQ-020 In HOLD, dout, sat_flag and dout_valid stay stable until dout_ready = 1.
REQ-021 HOLD with dout_ready = 1: transfer completes; next cycle state = ACC, accumulator = 0, count = 0, dout_valid = 0.
REQ-022 No sample can be accepted in the cycle a result drains; the first sample of the next window is accepted no earlier than the cycle after the drain.
REQ-023 dout_ready while dout_valid = 0 has no effect.
REQ-024 Window boundaries are sample-aligned only; partial windows never produce output.

Reset
REQ-025 While rst = 1: state = ACC, accumulator = 0, count = 0, dout = 0, sat_flag = 0, dout_valid = 0, din_ready = 1 (asynchronous, no clock needed).
REQ-026 Reset asserted mid-window or in HOLD discards the partial sum or pending result; no result for that window is ever output.
REQ-027 After rst deasserts, the first accepted sample starts a new window at count 0.

Verification (IW=4, OW=6, N=8)
REQ-028 8 consecutive accepts of -8 -> dout = -32 (clipped from -64), sat_flag = 1, dout_valid 1 cycle after the 8th accept.
REQ-029 8 accepts of +7 -> dout = +31 (clipped from 56), sat_flag = 1; 8 accepts alternating +3/-2 -> dout = +4, sat_flag = 0.
REQ-030 din_valid toggled 1,0,0,1,... with 8 valid samples of +1 spread over 20 cycles -> dout = +8; bubbles are not counted.
REQ-031 dout_ready held 0 for 5 cycles in HOLD -> dout, sat_flag and dout_valid stay constant, din_ready = 0 and din ignored; dout_ready = 1 -> dout_valid = 0 and din_ready = 1 next cycle.
REQ-032 Accept 3 samples of +5, pulse rst for 1 cycle, then 8 samples of +2 -> single result dout = +16, sat_flag = 0; the +5 samples do not contribute.
REQ-033 rst asserted in HOLD with dout_ready = 0 -> dout_valid = 0 immediately (asynchronous); no stale result after release.
